regfile: RTL and testbench
==========================

// Module: regfile
// PURPOSE
//  MIPS general-purpose register file, the responder to the decode stage's register interface.
//  Provides two async read ports and one sync write port (written back from WB stage).
//  $zero (r0) is hardwired to 0.
//  After reset, a sequential clear engine zeroes every entry; busy stalls the pipeline meanwhile.
// PARAMETERS
//  REG_NUM      32                 number of architectural registers (power of 2)
//  ADDR_W       `REG_ADDR_WIDTH    register address width (5); log2(REG_NUM)
//  DATA_W       `REG_DATA_WIDTH    register data width (32)
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  rst           in   1       synchronous reset, active-high
//  reg_rd_en1    in   1       read port 1 enable
//  reg_rd_addr1  in   ADDR_W  read port 1 address
//  reg_rd_data1  out  DATA_W  read port 1 data (combinational)
//  reg_rd_en2    in   1       read port 2 enable
//  reg_rd_addr2  in   ADDR_W  read port 2 address
//  reg_rd_data2  out  DATA_W  read port 2 data (combinational)
//  reg_wr_en     in   1       write enable (from WB)
//  reg_wr_addr   in   ADDR_W  write address
//  reg_wr_data   in   DATA_W  write data
//  busy          out  1       clear engine active; reads return 0, writes dropped
// BEHAVIOUR
//  - One clock, synchronous active-high reset (clk/rst); no async paths.
//  - FSM states: CLEAR, IDLE. A clk edge with rst=1 -> state<=CLEAR, clr_cnt<=0, busy<=1.
//  - CLEAR: each cycle mem[clr_cnt]<=0, clr_cnt<=clr_cnt+1.
//    When clr_cnt==REG_NUM-1 -> IDLE, busy<=0.
//    busy is high for exactly REG_NUM cycles after rst deasserts.
//  - rst during CLEAR restarts the clear from entry 0. rst in IDLE re-enters CLEAR.
//  - Reset values: busy=1, state=CLEAR, clr_cnt=0. Read data is 0 throughout reset/CLEAR.
//  - Write (IDLE only): reg_wr_en=1 and reg_wr_addr!=0 -> mem[reg_wr_addr]<=reg_wr_data at edge.
//    Writes to r0 are ignored. Writes while busy=1 are dropped (no queueing).
//  - Read port n (combinational, priority order):
//    1. rd_en=0 -> 0.
//    2. addr==0 -> 0.
//    3. busy=1 -> 0.
//    4. bypass hit (see CONFIGURATION) -> reg_wr_data.
//    5. Otherwise mem[addr].
//  - Both ports may read the same address in the same cycle; both return identical data.
//  - Read latency 0 (same cycle). Write visible to plain reads the cycle after the edge.
//  - clr_cnt width ADDR_W; wraps only at the CLEAR->IDLE exit, never inside IDLE.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    In IDLE, when reg_wr_en=1, reg_wr_addr!=0 and reg_wr_addr==rd_addr with rd_en=1,
//    read data = reg_wr_data in the same cycle (write-then-read forwarding, covers WB->ID hazard).
//  REGFILE_BYPASS_EN undefined:
//    No forwarding; the read returns the old mem value and the new value appears the next cycle.
// TESTING
//  1. rst=1 one cycle, then rst=0 -> busy=1 for exactly 32 cycles, then 0;
//     afterwards read r1..r31 -> all 0.
//  2. IDLE: write r5=0xDEADBEEF, next cycle rd_addr1=5 rd_en1=1 -> rd_data1=0xDEADBEEF;
//     rd_en1=0 -> 0.
//  3. Write r0=0x12345678, next cycle read r0 on both ports -> 0x00000000.
//  4. Same-cycle wr r7=0xA5A5A5A5 with rd_addr2=7 (r7 previously 0x1):
//     BYPASS_EN -> 0xA5A5A5A5, else -> 0x00000001; next cycle both -> 0xA5A5A5A5.
//  5. Write r3=0x55 in IDLE; assert rst mid-CLEAR at count 10; writes during busy dropped ->
//     busy high 32 cycles after second rst release; r3 reads 0.
//  6. Both ports read r9 (=0xCAFEF00D) same cycle -> both 0xCAFEF00D; port1 r9, port2 r10 independent.

Source files
------------

// File: rtl/regfile.sv
// MIPS register file: two combinational read ports, one synchronous write port, r0 hardwired to 0,
// and a post-reset clear engine. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module regfile #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = `REG_ADDR_WIDTH,
    parameter int DATA_W  = `REG_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_rd_en1,
    input  logic [ADDR_W-1:0] reg_rd_addr1,
    output logic [DATA_W-1:0] reg_rd_data1,
    input  logic              reg_rd_en2,
    input  logic [ADDR_W-1:0] reg_rd_addr2,
    output logic [DATA_W-1:0] reg_rd_data2,
    input  logic              reg_wr_en,
    input  logic [ADDR_W-1:0] reg_wr_addr,
    input  logic [DATA_W-1:0] reg_wr_data,
    output logic              busy,
    output logic [0:0]        dbg_state
);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [REG_NUM];
    logic              clr_last;
    logic              wr_ok;

    assign clr_last  = (clr_cnt_q == ADDR_W'(REG_NUM - 1));
    assign wr_ok     = (state_q == IDLE) && reg_wr_en && (reg_wr_addr != '0);
    assign busy      = busy_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        case (state_q)
            CLEAR: begin
                // Counter wraps to 0 exactly on the exit edge, ready for the next clear.
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            IDLE: begin
                busy_d = 1'b0;
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
                busy_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
        end
    end

    // Storage has no reset of its own; the clear engine is what zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (wr_ok) begin
                mem_q[reg_wr_addr] <= reg_wr_data;
            end
        end
    end

    always_comb begin
        reg_rd_data1 = '0;
        if (reg_rd_en1 && (reg_rd_addr1 != '0) && !busy_q) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (reg_wr_addr == reg_rd_addr1)) reg_rd_data1 = reg_wr_data;
            else                                        reg_rd_data1 = mem_q[reg_rd_addr1];
`else
            reg_rd_data1 = mem_q[reg_rd_addr1];
`endif
        end
    end

    always_comb begin
        reg_rd_data2 = '0;
        if (reg_rd_en2 && (reg_rd_addr2 != '0) && !busy_q) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (reg_wr_addr == reg_rd_addr2)) reg_rd_data2 = reg_wr_data;
            else                                        reg_rd_data2 = mem_q[reg_rd_addr2];
`else
            reg_rd_data2 = mem_q[reg_rd_addr2];
`endif
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: clear-engine timing, table-driven read/write vectors,
// bypass behaviour (follows REGFILE_BYPASS_EN) and reset-during-clear sequences.
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_rd_en1, reg_rd_en2, reg_wr_en;
    logic [4:0]  reg_rd_addr1, reg_rd_addr2, reg_wr_addr;
    logic [31:0] reg_rd_data1, reg_rd_data2, reg_wr_data;
    logic        busy;
    logic [0:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    regfile dut (
        .clk          (clk),
        .rst          (rst),
        .reg_rd_en1   (reg_rd_en1),
        .reg_rd_addr1 (reg_rd_addr1),
        .reg_rd_data1 (reg_rd_data1),
        .reg_rd_en2   (reg_rd_en2),
        .reg_rd_addr2 (reg_rd_addr2),
        .reg_rd_data2 (reg_rd_data2),
        .reg_wr_en    (reg_wr_en),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    typedef struct {
        logic        en1;
        logic [4:0]  a1;
        logic        en2;
        logic [4:0]  a2;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en1, input logic [4:0] a1, input logic en2, input logic [4:0] a2,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        reg_rd_en1 = en1; reg_rd_addr1 = a1;
        reg_rd_en2 = en2; reg_rd_addr2 = a2;
        reg_wr_en  = we;  reg_wr_addr  = wa; reg_wr_data = wd;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    endtask

    // Pulse rst over one rising edge; returns just after that edge with rst low.
    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Samples busy on each falling edge after a reset edge; sample i sees clear count i.
    // At sample wr_at a write to r2 is attempted and port 1 reads r31 while busy.
    task automatic count_busy(input int wr_at, output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (i == wr_at) begin
                drive(1'b1, 5'd31, 1'b1, 5'd2, 1'b1, 5'd2, 32'h0000_00FF);
                #1;
                check("busy_read_p1", reg_rd_data1, 32'h0);
                check("busy_read_p2", reg_rd_data2, 32'h0);
            end else begin
                idle_inputs();
            end
        end
        idle_inputs();
    endtask

    initial begin
        int n;
        logic [31:0] exp_byp;

        vecs[0] = '{1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 5'd5,  32'hDEAD_BEEF, 32'h0,          32'h0};
        vecs[1] = '{1'b1, 5'd5,  1'b0, 5'd5,  1'b1, 5'd0,  32'h1234_5678, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 5'd9,  32'hCAFE_F00D, 32'h0,          32'h0};
        vecs[3] = '{1'b1, 5'd9,  1'b1, 5'd9,  1'b1, 5'd10, 32'h0BAD_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 5'd9,  1'b1, 5'd10, 1'b1, 5'd7,  32'h0000_0001, 32'hCAFE_F00D, 32'h0BAD_F00D};
        vecs[5] = '{1'b1, 5'd7,  1'b1, 5'd5,  1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 32'hDEAD_BEEF};
        vecs[6] = '{1'b1, 5'd31, 1'b1, 5'd12, 1'b0, 5'd12, 32'h0000_0777, 32'hFFFF_FFFF, 32'h0};
        vecs[7] = '{1'b1, 5'd12, 1'b0, 5'd5,  1'b0, 5'd0,  32'h0,          32'h0,          32'h0};

        // reset state
        rst = 1'b1;
        drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h1);
        check("rst_state", {31'h0, dbg_state}, 32'h0);
        check("rst_rd1", reg_rd_data1, 32'h0);
        check("rst_rd2", reg_rd_data2, 32'h0);
        rst = 1'b0;
        count_busy(-1, n);
        check("clear1_busy_cycles", n, 32);
        check("idle_state", {31'h0, dbg_state}, 32'h1);

        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            drive(1'b1, 5'(a), 1'b1, 5'(32 - a), 1'b0, 5'd0, 32'h0);
            #1;
            check("post_clear_p1", reg_rd_data1, 32'h0);
            check("post_clear_p2", reg_rd_data2, 32'h0);
        end

        // table vectors: reads checked before the edge that performs the row's write
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].en1, vecs[i].a1, vecs[i].en2, vecs[i].a2, vecs[i].we, vecs[i].wa, vecs[i].wd);
            #1;
            check($sformatf("vec%0d_p1", i), reg_rd_data1, vecs[i].exp1);
            check($sformatf("vec%0d_p2", i), reg_rd_data2, vecs[i].exp2);
            check($sformatf("vec%0d_busy", i), {31'h0, busy}, 32'h0);
        end

        // same-cycle write/read of r7 (currently 1)
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'hA5A5_A5A5;
`else
        exp_byp = 32'h0000_0001;
`endif
        @(negedge clk);
        drive(1'b1, 5'd9, 1'b1, 5'd7, 1'b1, 5'd7, 32'hA5A5_A5A5);
        #1;
        check("bypass_p2", reg_rd_data2, exp_byp);
        check("bypass_p1_other", reg_rd_data1, 32'hCAFE_F00D);
        @(negedge clk);
        drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd7, 32'h0);
        #1;
        check("after_wr_p1", reg_rd_data1, 32'hA5A5_A5A5);
        check("after_wr_p2", reg_rd_data2, 32'hA5A5_A5A5);

        // write r3, then reset and restart the clear at count 10
        @(negedge clk);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h0000_0055);
        @(negedge clk);
        drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        #1;
        check("r3_written", reg_rd_data1, 32'h0000_0055);
        idle_inputs();
        pulse_reset();
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i == 10) begin
                check("mid_clear_busy", {31'h0, busy}, 32'h1);
                rst = 1'b1;
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        count_busy(20, n);
        check("clear2_busy_cycles", n, 32);
        @(negedge clk);
        drive(1'b1, 5'd3, 1'b1, 5'd2, 1'b0, 5'd0, 32'h0);
        #1;
        check("r3_cleared", reg_rd_data1, 32'h0);
        check("r2_write_dropped", reg_rd_data2, 32'h0);
        @(negedge clk);
        drive(1'b1, 5'd9, 1'b1, 5'd31, 1'b0, 5'd0, 32'h0);
        #1;
        check("r9_cleared", reg_rd_data1, 32'h0);
        check("r31_cleared", reg_rd_data2, 32'h0);

        // reset from IDLE after clear completes
        idle_inputs();
        pulse_reset();
        #1;
        check("idle_rst_state", {31'h0, dbg_state}, 32'h0);
        count_busy(-1, n);
        check("clear3_busy_cycles", n, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
